// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU scheduler: FSM states, opcode encodings and width helpers.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Result is twice the operand width so MUL never overflows.
  function automatic int res_width(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Requester, execution-unit and response signals of the scheduler; master is the scheduler side.
interface alu_sched_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  import alu_sched_pkg::*;

  localparam int IW = $clog2(N_REQ);
  localparam int RW = res_width(DW);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
  logic [N_REQ*2-1:0]  req_op;

  logic          unit_start;
  logic [DW-1:0] unit_a;
  logic [DW-1:0] unit_b;
  logic [1:0]    unit_op;
  logic          unit_rst;
  logic          unit_done;
  logic [RW-1:0] unit_result;

  logic          rsp_valid;
  logic [IW-1:0] rsp_id;
  logic [RW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;

  modport master (
    input  req_valid, req_a, req_b, req_op, unit_done, unit_result,
    output req_ready, unit_start, unit_a, unit_b, unit_op, unit_rst,
           rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport slave (
    output req_valid, req_a, req_b, req_op, unit_done, unit_result,
    input  req_ready, unit_start, unit_a, unit_b, unit_op, unit_rst,
           rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo N_REQ.
// Zero latency; grant is all-zero and grant_vld low when nothing is requested.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     grant_vld
);
  localparam int IW  = $clog2(N_REQ);
  localparam int IW1 = IW + 1;

  logic [IW1-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int j = 0; j < N_REQ; j++) begin
      // ptr < N_REQ, so one conditional subtract is enough to wrap.
      idx = {1'b0, ptr} + IW1'(j);
      if (idx >= IW1'(N_REQ)) idx = idx - IW1'(N_REQ);
      if (!grant_vld && req[idx[IW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[IW-1:0];
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one multi-cycle ALU among N_REQ requesters round-robin, one operation in flight, with a done watchdog.
// Response one cycle after unit_done (or TIMEOUT+2 cycles after accept); req_ready only in IDLE, held requests wait.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  alu_sched_if.master bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam int RW = res_width(DW);

  state_t state, state_nxt;

  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    id_q;
  logic [N_REQ-1:0] grant;
  logic             grant_vld;
  logic             accept;
  logic             wd_expired;
  logic [WW-1:0]    wd_cnt;
  logic [DW-1:0]    a_q;
  logic [DW-1:0]    b_q;
  logic [1:0]       op_q;
  logic [RW-1:0]    data_q;
  logic             err_q;

  logic [DW-1:0] a_arr  [N_REQ];
  logic [DW-1:0] b_arr  [N_REQ];
  logic [1:0]    op_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g]  = bus.req_a[g*DW +: DW];
    assign b_arr[g]  = bus.req_b[g*DW +: DW];
    assign op_arr[g] = bus.req_op[g*2 +: 2];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign accept     = (state == IDLE) && grant_vld;
  assign wd_expired = (wd_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = '0;
    bus.unit_start = 1'b0;
    bus.unit_rst   = 1'b0;
    bus.unit_a     = a_q;
    bus.unit_b     = b_q;
    bus.unit_op    = op_q;
    bus.rsp_valid  = 1'b0;
    bus.rsp_id     = '0;
    bus.rsp_data   = '0;
    bus.rsp_err    = 1'b0;
    bus.busy       = (state != IDLE);
    case (state)
      IDLE: begin
        // Reset is async, so ready must also be masked while it is held.
        bus.req_ready = reset ? '0 : grant;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.unit_start = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        if (bus.unit_done || wd_expired) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = id_q;
        bus.rsp_data  = data_q;
        bus.rsp_err   = err_q;
        bus.unit_rst  = err_q;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      wd_cnt <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= a_arr[grant_idx];
            b_q    <= b_arr[grant_idx];
            op_q   <= op_arr[grant_idx];
            id_q   <= grant_idx;
            rr_ptr <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          // A done arriving on the expiry cycle still counts as success.
          if (bus.unit_done) begin
            data_q <= bus.unit_result;
            err_q  <= 1'b0;
          end else if (wd_expired) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed + randomized bench for alu_sched with a transaction-level reference model and an ALU unit model.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int N_REQ   = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 64;
  localparam int RW      = 2 * DW;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_sched_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  alu_sched #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [N_REQ-1:0] rv;
  logic [DW-1:0]    ra  [N_REQ];
  logic [DW-1:0]    rb  [N_REQ];
  logic [1:0]       rop [N_REQ];

  int            cyc, acc_cyc, rsp_cyc, m_ptr, m_id;
  bit            m_idle, m_err;
  logic [DW-1:0] m_a, m_b;
  logic [1:0]    m_op;
  logic [RW-1:0] m_data;

  int            done_cnt, unit_k;
  bit            never_done, rand_k, force_res;
  logic [RW-1:0] forced_res, unit_res;

  bit            rsp_seen, last_err;
  int            last_lat, last_id, unit_rst_cnt, rst_base;
  logic [RW-1:0] last_data;
  int            grants[$];
  int            exp4[5] = '{0, 1, 2, 3, 0};
  int            exp3[3] = '{1, 3, 0};

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int ptr);
    for (int j = 0; j < N_REQ; j++)
      if (v[(ptr + j) % N_REQ]) return (ptr + j) % N_REQ;
    return -1;
  endfunction

  function automatic logic [RW-1:0] alu_ref(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic signed [RW-1:0] sa, sb;
    sa = {{DW{a[DW-1]}}, a};
    sb = {{DW{b[DW-1]}}, b};
    case (op)
      OP_ADD:  return sa + sb;
      OP_SUB:  return sa - sb;
      OP_MUL:  return sa * sb;
      default: return (sb == 0) ? '1 : sa / sb;
    endcase
  endfunction

  task automatic new_req(input int i);
    ra[i]  = DW'($urandom);
    rb[i]  = DW'($urandom);
    rop[i] = 2'($urandom_range(0, 3));
    rv[i]  = 1'b1;
  endtask

  task automatic drive_req();
    bus.req_valid = rv;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_a[i*DW +: DW] = ra[i];
      bus.req_b[i*DW +: DW] = rb[i];
      bus.req_op[i*2 +: 2]  = rop[i];
    end
  endtask

  task automatic check_cycle();
    int g;
    logic [N_REQ-1:0] exp_rdy;
    if (!m_idle && rsp_cyc < 0) begin
      if (bus.unit_done && cyc >= acc_cyc + 2) begin
        rsp_cyc = cyc + 1; m_err = 1'b0; m_data = bus.unit_result;
      end else if (cyc == acc_cyc + 1 + TIMEOUT) begin
        rsp_cyc = cyc + 1; m_err = 1'b1; m_data = '0;
      end
    end
    g = m_idle ? rr_pick(rv, m_ptr) : -1;
    exp_rdy = (g >= 0) ? (N_REQ'(1) << g) : '0;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("busy", 32'(bus.busy), 32'(!m_idle));
    chk("unit_start", 32'(bus.unit_start), 32'(!m_idle && cyc == acc_cyc + 1));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(!m_idle && cyc == rsp_cyc));
    chk("unit_rst", 32'(bus.unit_rst), 32'(!m_idle && cyc == rsp_cyc && m_err));
    unit_rst_cnt += int'(bus.unit_rst);
    if (bus.unit_start) begin
      chk("unit_a", 32'(bus.unit_a), 32'(m_a));
      chk("unit_b", 32'(bus.unit_b), 32'(m_b));
      chk("unit_op", 32'(bus.unit_op), 32'(m_op));
      if (!never_done) begin
        done_cnt = rand_k ? int'($urandom_range(1, 6)) : unit_k;
        unit_res = force_res ? forced_res : alu_ref(bus.unit_op, bus.unit_a, bus.unit_b);
      end
    end
    if (!m_idle && cyc == rsp_cyc) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      chk("rsp_data", 32'(bus.rsp_data), 32'(m_data));
      chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
      if (!m_err) chk("rsp_alu", 32'(bus.rsp_data), 32'(force_res ? forced_res : alu_ref(m_op, m_a, m_b)));
      rsp_seen  = 1'b1;
      last_lat  = cyc - acc_cyc;
      last_id   = int'(bus.rsp_id);
      last_data = bus.rsp_data;
      last_err  = bus.rsp_err;
      m_idle    = 1'b1;
    end else if (g >= 0) begin
      acc_cyc = cyc; rsp_cyc = -1; m_id = g;
      m_a = ra[g]; m_b = rb[g]; m_op = rop[g];
      m_ptr = (g + 1) % N_REQ;
      m_idle = 1'b0;
      grants.push_back(g);
      rv[g] = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    bus.unit_done   = 1'b0;
    bus.unit_result = '0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        bus.unit_done   = 1'b1;
        bus.unit_result = unit_res;
      end
    end
    drive_req();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic check_zero();
    chk("rst req_ready", 32'(bus.req_ready), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst unit_start", 32'(bus.unit_start), 0);
    chk("rst unit_rst", 32'(bus.unit_rst), 0);
    chk("rst unit_a", 32'(bus.unit_a), 0);
    chk("rst unit_b", 32'(bus.unit_b), 0);
    chk("rst unit_op", 32'(bus.unit_op), 0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst rsp_id", 32'(bus.rsp_id), 0);
    chk("rst rsp_data", 32'(bus.rsp_data), 0);
    chk("rst rsp_err", 32'(bus.rsp_err), 0);
  endtask

  task automatic reset_seq();
    reset = 1'b1;
    rv = '1;
    drive_req();
    done_cnt = 0;
    bus.unit_done   = 1'b0;
    bus.unit_result = '0;
    m_idle = 1'b1; m_ptr = 0; rsp_cyc = -1; acc_cyc = -100;
    #1 check_zero();
    repeat (2) begin
      @(posedge clk);
      #1 check_zero();
    end
    rv = '0;
    reset = 1'b0;
    cyc++;
    drive_req();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_until_rsp(input string tag, input int max_cyc);
    rsp_seen = 1'b0;
    for (int i = 0; i < max_cyc && !rsp_seen; i++) cycle();
    chk({tag, " rsp_seen"}, 32'(rsp_seen), 1);
  endtask

  initial begin
    rv = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ra[i] = '0; rb[i] = '0; rop[i] = '0;
    end
    cyc = 0; done_cnt = 0; unit_k = 3; unit_rst_cnt = 0;
    never_done = 1'b0; rand_k = 1'b0; force_res = 1'b0; forced_res = '0;
    #1;
    reset_seq();

    // Single ADD from requester 0: 5 + -3, unit answers 3 cycles after start.
    ra[0] = 8'd5; rb[0] = 8'hFD; rop[0] = OP_ADD; rv = 4'b0001; unit_k = 3;
    run_until_rsp("single", 20);
    chk("single lat", 32'(last_lat), 5);
    chk("single id", 32'(last_id), 0);
    chk("single data", 32'(last_data), 32'h0002);
    chk("single err", 32'(last_err), 0);
    cycle();

    // Reset while waiting on the unit; rr_ptr must come back to 0.
    rv = '0; new_req(2); unit_k = 20;
    repeat (4) cycle();
    chk("wait busy", 32'(bus.busy), 1);
    @(posedge clk);
    #3;
    reset_seq();

    // All four continuously valid: 0,1,2,3,0.
    grants.delete(); rand_k = 1'b1;
    for (int i = 0; i < 200 && grants.size() < 5; i++) begin
      for (int j = 0; j < N_REQ; j++) if (!rv[j]) new_req(j);
      cycle();
    end
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr4 grant%0d", i), 32'(grants.size() > i ? grants[i] : -1), 32'(exp4[i]));
    rv = '0;
    run_until_rsp("rr4 drain", 20);

    // Move rr_ptr to 2, then 0 and 3 compete: 3 first, then 0.
    grants.delete();
    new_req(1);
    run_until_rsp("ptr prep", 20);
    new_req(0); new_req(3);
    for (int i = 0; i < 100 && grants.size() < 3; i++) cycle();
    run_until_rsp("ptr drain", 20);
    for (int i = 0; i < 3; i++)
      chk($sformatf("ptr2 grant%0d", i), 32'(grants.size() > i ? grants[i] : -1), 32'(exp3[i]));

    // Unit never answers: abort at accept+TIMEOUT+2 with a single unit_rst.
    rand_k = 1'b0; never_done = 1'b1; rst_base = unit_rst_cnt;
    new_req(2);
    run_until_rsp("timeout", 100);
    chk("timeout lat", 32'(last_lat), 32'(TIMEOUT + 2));
    chk("timeout err", 32'(last_err), 1);
    chk("timeout data", 32'(last_data), 0);
    chk("timeout id", 32'(last_id), 2);
    chk("timeout unit_rst", 32'(unit_rst_cnt - rst_base), 1);
    never_done = 1'b0; unit_k = 2;
    new_req(1);
    run_until_rsp("post timeout", 20);
    chk("post timeout lat", 32'(last_lat), 4);
    chk("post timeout err", 32'(last_err), 0);
    chk("post timeout id", 32'(last_id), 1);

    // Done lands on the very last watchdog cycle: success wins.
    unit_k = TIMEOUT; force_res = 1'b1; forced_res = 16'h00FF; rst_base = unit_rst_cnt;
    new_req(0);
    run_until_rsp("edge", 100);
    chk("edge lat", 32'(last_lat), 32'(TIMEOUT + 2));
    chk("edge err", 32'(last_err), 0);
    chk("edge data", 32'(last_data), 32'h00FF);
    chk("edge unit_rst", 32'(unit_rst_cnt - rst_base), 0);
    force_res = 1'b0;

    // Random traffic with arrivals, withdrawals and variable unit latency.
    rand_k = 1'b1;
    repeat (600) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!rv[j] && $urandom_range(0, 3) == 0) new_req(j);
        else if (rv[j] && $urandom_range(0, 15) == 0) rv[j] = 1'b0;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one multi-cycle ALU execution unit among N_REQ requesters. Accepts one operation at a time over a per-requester valid/ready handshake, drives the unit's start/done handshake, and returns the tagged 16-bit result to the winner. A watchdog aborts and resets the unit if done never arrives.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DW, 8, operand width
- TIMEOUT, 64, max WAIT cycles before abort (>=4)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  request valid per requester
- req_ready  out  N_REQ  request accepted (one-hot or zero)
- req_a, req_b  in  N_REQ*DW  packed signed operands, requester i at [i*DW +: DW]
- req_op  in  N_REQ*2  packed opcode (ADD=0, SUB=1, MUL=2, DIV=3)
- unit_start  out  1  one-cycle start pulse to execution unit
- unit_a, unit_b  out  DW  latched operands to unit
- unit_op  out  2  latched opcode
- unit_rst  out  1  one-cycle synchronous reset pulse to unit on abort
- unit_done  in  1  unit completion pulse
- unit_result  in  2*DW  signed unit result, valid with unit_done
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  clog2(N_REQ)  requester index of response
- rsp_data  out  2*DW  result (0 on error)
- rsp_err  out  1  1 = timeout abort
- busy  out  1  high in any state except IDLE

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: req_ready combinational; one bit set for first valid requester scanning from rr_ptr upward, modulo N_REQ. Transfer on valid&ready: latch operands, opcode, id; rr_ptr <= id+1 mod N_REQ; go ISSUE. No valid: stay, req_ready=0.
- ISSUE: unit_start=1 with latched operands; clear watchdog; go WAIT. unit_done in ISSUE ignored.
- WAIT: unit_done=1 -> latch unit_result, err=0, go RESP. Else watchdog increments; at TIMEOUT-1 without done -> err=1, data=0, go RESP. done and timeout same cycle: done wins.
- RESP: rsp_valid=1 with rsp_id/rsp_data/rsp_err; unit_rst=1 iff err; go IDLE.
- req_ready zero outside IDLE; held requests wait, not dropped. unit_a/b/op hold until next accept.
- Requester that drops req_valid before ready loses nothing; no state retained for it.

## Timing
- Reset (async): state IDLE, rr_ptr 0, watchdog 0, all outputs 0 (req_ready 0 while in reset).
- Accept cycle T; unit_start at T+1; done at T+1+k (k>=1) -> rsp_valid at T+2+k; next accept earliest T+3+k.
- Timeout: rsp_valid exactly TIMEOUT+2 cycles after accept, rsp_err=1, unit_rst same cycle.
- Reset mid-operation: immediate return to IDLE, all outputs 0, response lost; unit is not pulsed unit_rst (system reset covers it).
- Throughput: one operation per k+3 cycles; no pipelining.

## Structure
- Package alu_sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP), opcode localparams, result/operand width helper.
- Sub-module rr_arbiter (N_REQ, req vector + pointer in, one-hot grant + index out, combinational); pointer register stays in alu_sched.
- Watchdog counter width clog2(TIMEOUT).

## Test plan
- Single request: req 0, a=5, b=-3, ADD; unit model done after 3 cycles with 2 -> rsp_valid at accept+5, id 0, data 0x0002, err 0.
- All four valid continuously: grants in order 0,1,2,3,0; each req_ready one-hot, never two operations overlapping.
- rr_ptr=2, requesters 0 and 3 valid -> grant 3, then 0.
- Unit never done, TIMEOUT=64 -> rsp_valid at accept+66, err 1, data 0, unit_rst one cycle, next request accepted normally.
- unit_done on exact timeout cycle with result 0x00FF -> err 0, data 0x00FF, no unit_rst; reset asserted in WAIT -> outputs 0 same cycle, IDLE after release, rr_ptr 0.
